multiplicador: RTL and testbench
================================

MULTIPLICADOR -- requirements
Module: multiplicador

Interface
REQ-001 Parameter: WIDTH, default 16, operand width; Produto is 2*WIDTH bits; all requirements below use WIDTH=16.
REQ-002 Clk  input  1  single clock; all state changes on rising edge.
REQ-003 Rst  input  1  asynchronous, active-low reset.
REQ-004 St  input  1  start request, level-sampled on rising Clk edge.
REQ-005 Multiplicando  input  16  unsigned multiplicand, sampled when a start is accepted.
REQ-006 Multiplicador  input  16  unsigned multiplier, sampled when a start is accepted.
REQ-007 Produto  output  32  unsigned product register.
REQ-008 Idle  output  1  high while ready to accept St.
REQ-009 Done  output  1  one-cycle completion pulse.

Function
REQ-010 The block SHALL be a sequential shift-and-add multiplier with three states: IDLE, CALC, DONE.
REQ-011 IDLE: Idle=1, Done=0; on an edge with St=1, the block SHALL latch both operands, clear the accumulator and the iteration counter, and go to CALC.
REQ-012 IDLE with St=0: the block SHALL remain in IDLE with Produto unchanged.
REQ-013 CALC: Idle=0, Done=0; each cycle, if the multiplier LSB is 1, the block SHALL add the multiplicand to the upper 16 bits of the 33-bit accumulator (carry kept), then shift the accumulator/multiplier pair right by one bit.
REQ-014 CALC SHALL last exactly 16 cycles (counter 0..15); after the 16th iteration, the block SHALL load the 32-bit result into Produto and go to DONE.
REQ-015 DONE: Done=1, Idle=0 for exactly one cycle; the block SHALL then go to IDLE unconditionally.
REQ-016 Latency: Done SHALL be high in the 17th cycle after the edge that accepted St (16 CALC + 1 DONE), independent of operand values.
REQ-017 Produto SHALL equal Multiplicando*Multiplicador (unsigned, exact, no overflow) from the DONE cycle and SHALL hold until the next completion or reset.
REQ-018 St asserted during CALC or DONE SHALL be ignored; operand input changes after acceptance SHALL have no effect on the running operation.
REQ-019 If St is still high in IDLE after DONE, a new operation SHALL start on that edge.
REQ-020 Operand value 0 SHALL complete with the same 17-cycle latency and Produto=0.

Reset
REQ-021 Rst=0 SHALL immediately (asynchronously) force state to IDLE, Produto=0, Idle=1, Done=0, and clear the accumulator, operand registers and counter.
REQ-022 Reset mid-CALC or in DONE SHALL abort the operation with no Done pulse; normal operation SHALL resume on the first edge after Rst returns high.
REQ-023 No output SHALL glitch to X after reset; all registers SHALL have defined reset values.

Verification
REQ-024 Reset, then St one cycle with 5 x 3 -> Idle falls, Done pulses one cycle 17 cycles later, Produto=15 (0x0000000F), Idle returns high.
REQ-025 Reset between operations, then 10 x 4 -> Produto=40 (0x00000028); during reset Produto=0, Idle=1.
REQ-026 Back-to-back without reset: 1000 x 50 after a prior result -> Produto=50000 (0x0000C350); prior result held until the new DONE cycle.
REQ-027 Boundary: 0xFFFF x 0xFFFF -> Produto=0xFFFE0001; 0 x 0x1234 -> Produto=0; both with 17-cycle latency.
REQ-028 St pulsed again during CALC with different operands -> ignored, original product delivered.
REQ-029 Rst asserted at CALC cycle 8 -> immediate IDLE, Produto=0, no Done pulse; subsequent 7 x 9 -> 63.

Source files
------------

// File: rtl/multiplicador_if.sv
// Handshake and data bundle for the shift-and-add multiplier.
// The master side issues start/operands; the slave side returns product and status.
interface multiplicador_if #(
   parameter int WIDTH = 16
);
   logic               st;
   logic [WIDTH-1:0]   multiplicando;
   logic [WIDTH-1:0]   multiplicador;
   logic [2*WIDTH-1:0] produto;
   logic               idle;
   logic               done;

   modport master (
      output st, multiplicando, multiplicador,
      input  produto, idle, done
   );

   modport slave (
      input  st, multiplicando, multiplicador,
      output produto, idle, done
   );
endinterface

// File: rtl/multiplicador.sv
// Sequential unsigned shift-and-add multiplier: WIDTH iterations in CALC,
// then a one-cycle DONE pulse with the exact product held in produto.
module multiplicador #(
   parameter int WIDTH = 16
) (
   input  logic           clk,
   input  logic           rst_n,
   multiplicador_if.slave bus
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t             state;
   state_t             state_nxt;
   logic [2*WIDTH:0]   acc;
   logic [2*WIDTH:0]   acc_nxt;
   logic [WIDTH-1:0]   mcand;
   logic [CNT_W-1:0]   cnt;
   logic [2*WIDTH-1:0] produto_r;
   logic               idle_c;
   logic               done_c;

   // The multiplier occupies the low half of acc and is consumed as the sum
   // shifts in from the top; bit 2*WIDTH catches the carry of the add.
   function automatic logic [2*WIDTH:0] shift_add(input logic [2*WIDTH:0] a,
                                                  input logic [WIDTH-1:0] m);
      logic [WIDTH:0] sum;
      sum = a[2*WIDTH:WIDTH] + (a[0] ? {1'b0, m} : {(WIDTH+1){1'b0}});
      return {1'b0, sum, a[WIDTH-1:1]};
   endfunction

   assign acc_nxt = shift_add(acc, mcand);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      idle_c    = 1'b0;
      done_c    = 1'b0;
      case (state)
         IDLE: begin
            idle_c = 1'b1;
            if (bus.st) state_nxt = CALC;
         end
         CALC: begin
            if (cnt == CNT_LAST) state_nxt = DONE;
         end
         DONE: begin
            done_c    = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc       <= '0;
         mcand     <= '0;
         cnt       <= '0;
         produto_r <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.st) begin
                  mcand <= bus.multiplicando;
                  acc   <= {{(WIDTH+1){1'b0}}, bus.multiplicador};
                  cnt   <= '0;
               end
            end
            CALC: begin
               acc <= acc_nxt;
               cnt <= cnt + 1'b1;
               // Final iteration: the shifted value is already the full product.
               if (cnt == CNT_LAST) produto_r <= acc_nxt[2*WIDTH-1:0];
            end
            default: ;
         endcase
      end
   end

   assign bus.produto = produto_r;
   assign bus.idle    = idle_c;
   assign bus.done    = done_c;

endmodule

// File: tb/tb_multiplicador.sv
// Randomized self-checking bench for multiplicador: product and cycle-exact
// Idle/Done timing compared against a plain arithmetic reference.
module tb_multiplicador;

   localparam int WIDTH = 16;
   localparam int LAT   = 17;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_pass;
   logic [31:0] last_prod;

   multiplicador_if #(.WIDTH(WIDTH)) bus ();

   multiplicador #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   // One operation from the IDLE negedge. poke: CALC cycle in which a bogus
   // start with other operands is pulsed (0 = none). abort_at: CALC cycle in
   // which reset is asserted (0 = none).
   task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                         input int poke, input int abort_at);
      logic [31:0] expv;
      expv = {16'h0, a} * {16'h0, b};
      check("idle_before", {31'h0, bus.idle}, 32'd1);
      bus.st            = 1'b1;
      bus.multiplicando = a;
      bus.multiplicador = b;
      for (int k = 1; k <= 16; k++) begin
         tick();
         bus.st            = (k == poke);
         bus.multiplicando = 16'($urandom);
         bus.multiplicador = 16'($urandom);
         if (k == abort_at) begin
            rst_n = 1'b0;
            #1;
            check("abort_prod", bus.produto, 32'h0);
            check("abort_idle", {31'h0, bus.idle}, 32'd1);
            check("abort_done", {31'h0, bus.done}, 32'd0);
            bus.st = 1'b0;
            @(negedge clk);
            tick();
            check("abort_nodone", {31'h0, bus.done}, 32'd0);
            rst_n     = 1'b1;
            last_prod = 32'h0;
            return;
         end
         if (k == 1 || k == 8 || k == 16) begin
            check("calc_idle", {31'h0, bus.idle}, 32'd0);
            check("calc_hold", bus.produto, last_prod);
         end
         check("calc_done", {31'h0, bus.done}, 32'd0);
      end
      tick();
      bus.st = 1'b0;
      check("done_pulse", {31'h0, bus.done}, 32'd1);
      check("done_idle", {31'h0, bus.idle}, 32'd0);
      check("product", bus.produto, expv);
      tick();
      check("post_done", {31'h0, bus.done}, 32'd0);
      check("post_idle", {31'h0, bus.idle}, 32'd1);
      check("post_hold", bus.produto, expv);
      last_prod = expv;
   endtask

   initial begin
      logic [15:0] ra, rb;
      logic [31:0] e1, e2;
      n_checks          = 0;
      n_pass            = 0;
      last_prod         = 32'h0;
      rst_n             = 1'b0;
      bus.st            = 1'b0;
      bus.multiplicando = 16'h0;
      bus.multiplicador = 16'h0;
      #1;
      check("rst_prod", bus.produto, 32'h0);
      check("rst_idle", {31'h0, bus.idle}, 32'd1);
      check("rst_done", {31'h0, bus.done}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      run_op(16'd5, 16'd3, 0, 0);

      rst_n = 1'b0;
      #1;
      check("rst2_prod", bus.produto, 32'h0);
      check("rst2_idle", {31'h0, bus.idle}, 32'd1);
      @(negedge clk);
      rst_n     = 1'b1;
      last_prod = 32'h0;
      tick();
      run_op(16'd10, 16'd4, 0, 0);
      run_op(16'd1000, 16'd50, 0, 0);
      run_op(16'hFFFF, 16'hFFFF, 0, 0);
      run_op(16'h0000, 16'h1234, 0, 0);
      run_op(16'h1234, 16'h0000, 0, 0);
      run_op(16'd321, 16'd123, 5, 0);
      run_op(16'd77, 16'd88, 0, 8);
      tick();
      run_op(16'd7, 16'd9, 0, 0);

      // St held high through DONE restarts on the first IDLE edge.
      ra = 16'($urandom);
      rb = 16'($urandom);
      e1 = {16'h0, 16'd300} * {16'h0, 16'd200};
      e2 = {16'h0, ra} * {16'h0, rb};
      bus.st            = 1'b1;
      bus.multiplicando = 16'd300;
      bus.multiplicador = 16'd200;
      repeat (LAT) tick();
      check("b2b_done1", {31'h0, bus.done}, 32'd1);
      check("b2b_prod1", bus.produto, e1);
      tick();
      check("b2b_idle", {31'h0, bus.idle}, 32'd1);
      bus.multiplicando = ra;
      bus.multiplicador = rb;
      tick();
      bus.st = 1'b0;
      check("b2b_busy", {31'h0, bus.idle}, 32'd0);
      repeat (LAT - 2) tick();
      check("b2b_hold", bus.produto, e1);
      tick();
      check("b2b_done2", {31'h0, bus.done}, 32'd1);
      check("b2b_prod2", bus.produto, e2);
      tick();
      last_prod = e2;

      for (int i = 0; i < 24; i++) begin
         case ($urandom_range(0, 5))
            0:       begin ra = 16'h0;    rb = 16'($urandom); end
            1:       begin ra = 16'hFFFF; rb = 16'($urandom); end
            default: begin ra = 16'($urandom); rb = 16'($urandom); end
         endcase
         run_op(ra, rb, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 16)) : 0, 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
